// File: rtl/jtframe_z80_romrq.sv
// jtframe_z80_romrq: answers CPU ROM reads from a two-entry word cache.
// Misses are fetched from SDRAM over a req/ack/dok handshake.
// A hit is combinational, so rom_ok rises in the same cycle as rom_cs.
module jtframe_z80_romrq #(
  parameter int AW     = 15,
  parameter int OFFSET = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic [AW-1:0] addr,
  input  logic          rom_cs,
  output logic          rom_ok,
  output logic [7:0]    dout,
  output logic [AW-2:0] sdram_addr,
  output logic          sdram_req,
  input  logic          sdram_ack,
  input  logic          sdram_dok,
  input  logic [15:0]   sdram_din
);

  localparam int WW = AW - 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic          sdram_req_q, sdram_req_d;
  logic [WW-1:0] sdram_addr_q, sdram_addr_d;
  logic [WW-1:0] fill_tag_q, fill_tag_d;
  logic          drop_q, drop_d;
  logic          victim_q, victim_d;
  logic [1:0]    valid_q, valid_d;
  logic [WW-1:0] tag_q  [2];
  logic [WW-1:0] tag_d  [2];
  logic [15:0]   data_q [2];
  logic [15:0]   data_d [2];

  logic [WW-1:0] word_addr;
  logic          hit0, hit1, hit;
  logic [15:0]   hit_data;
  logic          fetch_done;

  assign word_addr = addr[AW-1:1];

  // Lookup always sees the contents before any fill in this cycle.
  always_comb begin
    hit0     = valid_q[0] && (tag_q[0] == word_addr);
    hit1     = valid_q[1] && (tag_q[1] == word_addr);
    hit      = hit0 || hit1;
    hit_data = hit0 ? data_q[0] : data_q[1];
    rom_ok   = rom_cs && hit && !clr;
    if (!hit)
      dout = 8'h00;
    else if (addr[0])
      dout = hit_data[15:8];
    else
      dout = hit_data[7:0];
  end

  assign sdram_req  = sdram_req_q;
  assign sdram_addr = sdram_addr_q;

  // Next-state: request FSM, fill into the victim entry, flush on clr.
  always_comb begin
    state_d      = state_q;
    sdram_req_d  = sdram_req_q;
    sdram_addr_d = sdram_addr_q;
    fill_tag_d   = fill_tag_q;
    drop_d       = drop_q;
    victim_d     = victim_q;
    valid_d      = valid_q;
    tag_d        = tag_q;
    data_d       = data_q;
    fetch_done   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (rom_cs && !hit && !clr) begin
          sdram_addr_d = word_addr + WW'(OFFSET);
          fill_tag_d   = word_addr;
          sdram_req_d  = 1'b1;
          drop_d       = 1'b0;
          state_d      = ST_REQ;
        end
      end
      ST_REQ: begin
        if (sdram_ack) begin
          sdram_req_d = 1'b0;
          if (sdram_dok) begin
            fetch_done = 1'b1;
            state_d    = ST_IDLE;
          end else begin
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (sdram_dok) begin
          fetch_done = 1'b1;
          state_d    = ST_IDLE;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        sdram_req_d = 1'b0;
      end
    endcase

    if (fetch_done) begin
      drop_d = 1'b0;
      if (!drop_q && !clr) begin
        valid_d[victim_q] = 1'b1;
        tag_d[victim_q]   = fill_tag_q;
        data_d[victim_q]  = sdram_din;
        victim_d          = ~victim_q;
      end
    end

    // A flush mid-fetch lets the handshake finish but discards its data.
    if (clr) begin
      valid_d  = 2'b00;
      victim_d = 1'b0;
      if (state_q != ST_IDLE && !fetch_done)
        drop_d = 1'b1;
    end
  end

  // Registers with synchronous reset; cache payload needs no reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      sdram_req_q  <= 1'b0;
      sdram_addr_q <= '0;
      fill_tag_q   <= '0;
      drop_q       <= 1'b0;
      victim_q     <= 1'b0;
      valid_q      <= 2'b00;
    end else begin
      state_q      <= state_d;
      sdram_req_q  <= sdram_req_d;
      sdram_addr_q <= sdram_addr_d;
      fill_tag_q   <= fill_tag_d;
      drop_q       <= drop_d;
      victim_q     <= victim_d;
      valid_q      <= valid_d;
    end
  end

  // Cache tags and data.
  always_ff @(posedge clk) begin
    tag_q  <= tag_d;
    data_q <= data_d;
  end

endmodule

// File: tb/tb_jtframe_z80_romrq.sv
// Directed bench for jtframe_z80_romrq; two instances share stimulus,
// the second one with a region offset that wraps.
module tb_jtframe_z80_romrq;

  logic        clk = 1'b0;
  logic        rst, clr, rom_cs, sdram_ack, sdram_dok;
  logic [14:0] addr;
  logic [15:0] sdram_din;
  logic        rom_ok0, req0, rom_ok1, req1;
  logic [7:0]  dout0, dout1;
  logic [13:0] sa0, sa1;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  jtframe_z80_romrq #(.AW(15), .OFFSET(0)) dut0 (
    .clk(clk), .rst(rst), .clr(clr), .addr(addr), .rom_cs(rom_cs),
    .rom_ok(rom_ok0), .dout(dout0), .sdram_addr(sa0), .sdram_req(req0),
    .sdram_ack(sdram_ack), .sdram_dok(sdram_dok), .sdram_din(sdram_din)
  );

  jtframe_z80_romrq #(.AW(15), .OFFSET(32'h4000)) dut1 (
    .clk(clk), .rst(rst), .clr(clr), .addr(addr), .rom_cs(rom_cs),
    .rom_ok(rom_ok1), .dout(dout1), .sdram_addr(sa1), .sdram_req(req1),
    .sdram_ack(sdram_ack), .sdram_dok(sdram_dok), .sdram_din(sdram_din)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Miss on a, ack next cycle, dok the cycle after, then expect a hit.
  task automatic fetch(input logic [14:0] a, input logic [15:0] din, input logic [13:0] exp_sa);
    addr   = a;
    rom_cs = 1'b1;
    tick();
    check("fetch_req", req0, 1);
    check("fetch_addr", sa0, exp_sa);
    sdram_ack = 1'b1;
    tick();
    sdram_ack = 1'b0;
    sdram_dok = 1'b1;
    sdram_din = din;
    tick();
    sdram_dok = 1'b0;
    #1;
    check("fetch_hit", rom_ok0, 1);
  endtask

  initial begin
    rst = 1'b1; clr = 1'b0; rom_cs = 1'b0; addr = '0;
    sdram_ack = 1'b0; sdram_dok = 1'b0; sdram_din = '0;
    tick(); tick();
    rst = 1'b0;
    #1;
    check("rst_req", req0, 0);
    check("rst_addr", sa0, 0);
    check("rst_ok", rom_ok0, 0);

    // Miss then hit
    addr = 15'h0102; rom_cs = 1'b1;
    #1;
    check("miss_ok", rom_ok0, 0);
    tick();
    check("miss_req", req0, 1);
    check("miss_sa", sa0, 14'h0081);
    tick();
    check("req_hold", req0, 1);
    sdram_ack = 1'b1;
    tick();
    sdram_ack = 1'b0;
    check("req_drop", req0, 0);
    tick(); tick();
    sdram_dok = 1'b1; sdram_din = 16'hBEEF;
    #1;
    check("dok_cycle_ok", rom_ok0, 0);
    tick();
    sdram_dok = 1'b0;
    #1;
    check("after_dok_ok", rom_ok0, 1);
    check("after_dok_dout", dout0, 8'hEF);
    addr = 15'h0103;
    #1;
    check("hi_ok", rom_ok0, 1);
    check("hi_dout", dout0, 8'hBE);
    tick();
    check("hi_noreq", req0, 0);

    // Round robin
    rom_cs = 1'b0; clr = 1'b1;
    tick();
    clr = 1'b0;
    fetch(15'h0010, 16'h1111, 14'h0008);
    fetch(15'h0020, 16'h2222, 14'h0010);
    fetch(15'h0030, 16'h3333, 14'h0018);
    addr = 15'h0020; #1;
    check("rr_20_ok", rom_ok0, 1);
    check("rr_20_dout", dout0, 8'h22);
    addr = 15'h0021; #1;
    check("rr_21_ok", rom_ok0, 1);
    addr = 15'h0031; #1;
    check("rr_31_dout", dout0, 8'h33);
    addr = 15'h0010; #1;
    check("rr_10_miss", rom_ok0, 0);
    fetch(15'h0010, 16'h1010, 14'h0008);
    addr = 15'h0020; #1;
    check("rr_20_evicted", rom_ok0, 0);

    // ack and dok together
    addr = 15'h0040;
    tick();
    check("ad_req", req0, 1);
    sdram_ack = 1'b1; sdram_dok = 1'b1; sdram_din = 16'h4444;
    tick();
    sdram_ack = 1'b0; sdram_dok = 1'b0;
    #1;
    check("ad_req_low", req0, 0);
    check("ad_ok", rom_ok0, 1);
    check("ad_dout", dout0, 8'h44);
    tick();
    check("ad_no_second", req0, 0);

    // Address moves during fetch
    addr = 15'h0200;
    tick();
    check("mv_sa", sa0, 14'h0100);
    sdram_ack = 1'b1;
    tick();
    sdram_ack = 1'b0;
    addr = 15'h0011; #1;
    check("mv_cached_ok", rom_ok0, 1);
    check("mv_cached_dout", dout0, 8'h10);
    tick();
    check("mv_noreq", req0, 0);
    sdram_dok = 1'b1; sdram_din = 16'hA55A;
    tick();
    sdram_dok = 1'b0;
    addr = 15'h0200; #1;
    check("mv_200_ok", rom_ok0, 1);
    check("mv_200_dout", dout0, 8'h5A);
    addr = 15'h0201; #1;
    check("mv_201_dout", dout0, 8'hA5);
    addr = 15'h0040; #1;
    check("mv_40_kept", dout0, 8'h44);
    tick();
    check("mv_idle_noreq", req0, 0);

    // clr during WAIT
    addr = 15'h0300;
    tick();
    check("clr_sa", sa0, 14'h0180);
    sdram_ack = 1'b1;
    tick();
    sdram_ack = 1'b0;
    addr = 15'h0040; #1;
    check("clr_pre_ok", rom_ok0, 1);
    clr = 1'b1; #1;
    check("clr_cycle_ok", rom_ok0, 0);
    tick();
    clr = 1'b0; #1;
    check("clr_flushed", rom_ok0, 0);
    rom_cs = 1'b0;
    sdram_dok = 1'b1; sdram_din = 16'h7777;
    tick();
    sdram_dok = 1'b0;
    addr = 15'h0300; rom_cs = 1'b1; #1;
    check("clr_suppressed", rom_ok0, 0);
    tick();
    check("clr_fresh_req", req0, 1);
    check("clr_fresh_sa", sa0, 14'h0180);
    sdram_ack = 1'b1;
    tick();
    sdram_ack = 1'b0;
    sdram_dok = 1'b1; clr = 1'b1; sdram_din = 16'h8888;
    tick();
    sdram_dok = 1'b0; clr = 1'b0; #1;
    check("clr_dok_invalid", rom_ok0, 0);
    tick();
    check("clr_dok_rereq", req0, 1);
    sdram_ack = 1'b1;
    tick();
    sdram_ack = 1'b0;
    sdram_dok = 1'b1; sdram_din = 16'h9999;
    tick();
    sdram_dok = 1'b0; #1;
    check("clr_refill_ok", rom_ok0, 1);
    check("clr_refill_dout", dout0, 8'h99);

    // Reset mid-fetch and OFFSET wrap
    addr = 15'h0500;
    tick();
    check("off_req", req1, 1);
    check("off_sa_wrap", sa1, 14'h0280);
    rst = 1'b1; rom_cs = 1'b0;
    tick();
    rst = 1'b0;
    check("rst_mid_req0", req0, 0);
    check("rst_mid_req1", req1, 0);
    check("rst_mid_sa1", sa1, 0);
    sdram_ack = 1'b1; sdram_dok = 1'b1; sdram_din = 16'h1234;
    tick();
    sdram_ack = 1'b0; sdram_dok = 1'b0; #1;
    check("late_dok_dout", dout1, 8'h00);
    check("late_dok_req", req1, 0);
    addr = 15'h7FFE; rom_cs = 1'b1;
    tick();
    check("off_7ffe_req", req1, 1);
    check("off_7ffe_sa", sa1, 14'h3FFF);
    sdram_ack = 1'b1;
    tick();
    sdram_ack = 1'b0;
    sdram_dok = 1'b1; sdram_din = 16'hCAFE;
    tick();
    sdram_dok = 1'b0; #1;
    check("off_ok", rom_ok1, 1);
    check("off_lo", dout1, 8'hFE);
    addr = 15'h7FFF; #1;
    check("off_hi", dout1, 8'hCA);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
